// File: rtl/mode_key_debounce.sv
// Front-panel mode keys: per-key 2-flop synchronizer and counter debounce, then a
// latched active-low one-hot modulation mode select with a one-cycle change pulse.
module mode_key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] key_in,
    output logic       set_ask,
    output logic       set_fsk,
    output logic       set_psk,
    output logic       set_dpsk,
    output logic [3:0] key_state,
    output logic       mode_changed
);

    typedef enum logic [3:0] {
        MODE_ASK  = 4'b0111,
        MODE_FSK  = 4'b1011,
        MODE_PSK  = 4'b1101,
        MODE_DPSK = 4'b1110
    } mode_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || (64'(1) << CNT_W) < 64'(DEBOUNCE_CYCLES)) begin : g_param_check
        $error("mode_key_debounce: DEBOUNCE_CYCLES must be >= 2 and fit in CNT_W bits");
    end

    logic [3:0] press;

    genvar gi;
    for (gi = 0; gi < 4; gi++) begin : g_key
        logic             sync1_q;
        logic             sync2_q;
        logic             stable_q;
        logic             stable_d;
        logic             stable_dly_q;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;

        // Any sample equal to the stable level restarts the count, so only an
        // unbroken run of DEBOUNCE_CYCLES differing samples is accepted.
        always_comb begin
            cnt_d    = cnt_q;
            stable_d = stable_q;
            if (sync2_q == stable_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                sync1_q      <= 1'b1;
                sync2_q      <= 1'b1;
                stable_q     <= 1'b1;
                stable_dly_q <= 1'b1;
                cnt_q        <= '0;
            end else begin
                sync1_q      <= key_in[gi];
                sync2_q      <= sync1_q;
                stable_q     <= stable_d;
                stable_dly_q <= stable_q;
                cnt_q        <= cnt_d;
            end
        end

        assign press[gi]     = stable_dly_q & ~stable_q;
        assign key_state[gi] = stable_q;
    end

    mode_e mode_q;
    logic  mode_changed_q;

    // Highest-priority press wins; re-pressing the current mode's key is silent.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_q         <= MODE_ASK;
            mode_changed_q <= 1'b0;
        end else begin
            mode_changed_q <= 1'b0;
            if (press[3]) begin
                mode_q         <= MODE_ASK;
                mode_changed_q <= (mode_q != MODE_ASK);
            end else if (press[2]) begin
                mode_q         <= MODE_FSK;
                mode_changed_q <= (mode_q != MODE_FSK);
            end else if (press[1]) begin
                mode_q         <= MODE_PSK;
                mode_changed_q <= (mode_q != MODE_PSK);
            end else if (press[0]) begin
                mode_q         <= MODE_DPSK;
                mode_changed_q <= (mode_q != MODE_DPSK);
            end
        end
    end

    assign {set_ask, set_fsk, set_psk, set_dpsk} = mode_q;
    assign mode_changed                          = mode_changed_q;

endmodule

// File: tb/tb_mode_key_debounce.sv
// Bench for mode_key_debounce with an 8-cycle debounce: directed vector table,
// hand-written reset-mid-debounce sequence, and random keys against a window model.
module tb_mode_key_debounce;

    localparam int D = 8;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] key_in  = 4'hF;
    logic       set_ask, set_fsk, set_psk, set_dpsk;
    logic [3:0] key_state;
    logic       mode_changed;

    int vec_cnt = 0;
    int err_cnt = 0;

    mode_key_debounce #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .key_in      (key_in),
        .set_ask     (set_ask),
        .set_fsk     (set_fsk),
        .set_psk     (set_psk),
        .set_dpsk    (set_dpsk),
        .key_state   (key_state),
        .mode_changed(mode_changed)
    );

    always #5 clk = ~clk;

    // Reference: a key's debounced level flips once the last D synchronized
    // samples (input delayed two cycles) all disagree with it; a fall selects a
    // mode one cycle later, highest-priority key first.
    logic [3:0] hist[$];
    logic [3:0] m_stable, m_mode, m_press;
    logic       m_mc;

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < D + 2; i++) hist.push_back(4'hF);
        m_stable = 4'hF;
        m_mode   = 4'b0111;
        m_press  = 4'h0;
        m_mc     = 1'b0;
    endtask

    task automatic model_edge(input logic [3:0] k);
        logic [3:0] new_mode;
        logic [3:0] new_stable;
        logic       all_diff;
        new_mode = m_mode;
        if (m_press[3])      new_mode = 4'b0111;
        else if (m_press[2]) new_mode = 4'b1011;
        else if (m_press[1]) new_mode = 4'b1101;
        else if (m_press[0]) new_mode = 4'b1110;
        m_mc   = (new_mode != m_mode);
        m_mode = new_mode;
        hist.push_back(k);
        for (int i = 0; i < 4; i++) begin
            all_diff = 1'b1;
            for (int j = 0; j < D; j++)
                if (hist[hist.size() - 3 - j][i] == m_stable[i]) all_diff = 1'b0;
            new_stable[i] = all_diff ? ~m_stable[i] : m_stable[i];
        end
        m_press  = m_stable & ~new_stable;
        m_stable = new_stable;
        while (hist.size() > D + 4) void'(hist.pop_front());
    endtask

    task automatic check(input string name, input logic [3:0] st, input logic [3:0] md, input logic mc);
        logic [3:0] mode_now;
        mode_now = {set_ask, set_fsk, set_psk, set_dpsk};
        vec_cnt++;
        if ({key_state, mode_now, mode_changed} !== {st, md, mc}) begin
            err_cnt++;
            $display("FAIL %s: got key_state=%b set=%b mode_changed=%b, want key_state=%b set=%b mode_changed=%b",
                     name, key_state, mode_now, mode_changed, st, md, mc);
        end
    endtask

    // Called at a falling edge: drive, advance one clock, then compare to the model.
    task automatic tick(input logic [3:0] k);
        key_in = k;
        @(posedge clk);
        model_edge(k);
        @(negedge clk);
        check("model", m_stable, m_mode, m_mc);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        model_reset();
        check("reset", 4'hF, 4'h7, 1'b0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic [3:0] key;
        int         hold;
        logic [3:0] exp_state;
        logic [3:0] exp_mode;
        logic       exp_mc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [3:0] k, input int h, input logic [3:0] st,
                                input logic [3:0] md, input logic mc);
        vec_t v;
        v.key = k; v.hold = h; v.exp_state = st; v.exp_mode = md; v.exp_mc = mc;
        return v;
    endfunction

    initial begin
        // Idle after reset
        tbl.push_back(mk(4'hF, 50, 4'hF, 4'h7, 1'b0));
        // Clean PSK press: key_state at 10th edge, mode and pulse at 11th
        tbl.push_back(mk(4'hD, 9, 4'hF, 4'h7, 1'b0));
        tbl.push_back(mk(4'hD, 1, 4'hD, 4'h7, 1'b0));
        tbl.push_back(mk(4'hD, 1, 4'hD, 4'hD, 1'b1));
        tbl.push_back(mk(4'hD, 1, 4'hD, 4'hD, 1'b0));
        tbl.push_back(mk(4'hF, 20, 4'hF, 4'hD, 1'b0));
        // Back to ASK so the bounce test produces a real change
        tbl.push_back(mk(4'h7, 9, 4'hF, 4'hD, 1'b0));
        tbl.push_back(mk(4'h7, 1, 4'h7, 4'hD, 1'b0));
        tbl.push_back(mk(4'h7, 1, 4'h7, 4'h7, 1'b1));
        tbl.push_back(mk(4'h7, 1, 4'h7, 4'h7, 1'b0));
        tbl.push_back(mk(4'hF, 20, 4'hF, 4'h7, 1'b0));
        // Bouncing PSK press
        tbl.push_back(mk(4'hD, 5, 4'hF, 4'h7, 1'b0));
        tbl.push_back(mk(4'hF, 1, 4'hF, 4'h7, 1'b0));
        tbl.push_back(mk(4'hD, 5, 4'hF, 4'h7, 1'b0));
        tbl.push_back(mk(4'hF, 1, 4'hF, 4'h7, 1'b0));
        tbl.push_back(mk(4'hD, 9, 4'hF, 4'h7, 1'b0));
        tbl.push_back(mk(4'hD, 1, 4'hD, 4'h7, 1'b0));
        tbl.push_back(mk(4'hD, 1, 4'hD, 4'hD, 1'b1));
        tbl.push_back(mk(4'hD, 1, 4'hD, 4'hD, 1'b0));
        // FSK and DPSK together (PSK released on the same edge): FSK wins
        tbl.push_back(mk(4'hA, 11, 4'hA, 4'hB, 1'b1));
        tbl.push_back(mk(4'hA, 1, 4'hA, 4'hB, 1'b0));
        // Release FSK with DPSK held: no change
        tbl.push_back(mk(4'hE, 20, 4'hE, 4'hB, 1'b0));
        // Re-press FSK while in FSK: key_state moves, mode and pulse do not
        tbl.push_back(mk(4'hA, 9, 4'hE, 4'hB, 1'b0));
        tbl.push_back(mk(4'hA, 1, 4'hA, 4'hB, 1'b0));
        tbl.push_back(mk(4'hA, 1, 4'hA, 4'hB, 1'b0));
        tbl.push_back(mk(4'hF, 20, 4'hF, 4'hB, 1'b0));

        model_reset();
        do_reset();
        foreach (tbl[i]) begin
            for (int h = 0; h < tbl[i].hold; h++) tick(tbl[i].key);
            check($sformatf("vec%0d", i), tbl[i].exp_state, tbl[i].exp_mode, tbl[i].exp_mc);
        end

        // Reset while DPSK is at count 5, key held through reset release
        for (int h = 0; h < 7; h++) tick(4'hE);
        reset_n = 1'b0;
        #1;
        model_reset();
        check("mid_reset", 4'hF, 4'h7, 1'b0);
        repeat (3) @(negedge clk);
        check("in_reset", 4'hF, 4'h7, 1'b0);
        reset_n = 1'b1;
        for (int h = 0; h < 9; h++) tick(4'hE);
        check("dpsk_pre", 4'hF, 4'h7, 1'b0);
        tick(4'hE);
        check("dpsk_state", 4'hE, 4'h7, 1'b0);
        tick(4'hE);
        check("dpsk_mode", 4'hE, 4'hE, 1'b1);
        tick(4'hE);
        check("dpsk_clear", 4'hE, 4'hE, 1'b0);

        // Random key activity against the model
        do_reset();
        begin
            logic [3:0] k;
            k = 4'hF;
            for (int s = 0; s < 150; s++) begin
                case ($urandom_range(0, 3))
                    0: k = ~(4'b0001 << $urandom_range(0, 3));
                    1: k = 4'($urandom);
                    2: k = 4'hF;
                    default: k = k;
                endcase
                for (int h = 0, n = $urandom_range(1, 14); h < n; h++) tick(k);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
